// File: rtl/frame_checker_if.sv
// frame_checker_if: Avalon-MM slave and AXI-Stream sink bundle for frame_checker
// master: bench/upstream side (drives stream and bus requests); slave: frame_checker
interface frame_checker_if;
  logic [7:0]  writedata;
  logic        write;
  logic        chipselect;
  logic [7:0]  address;
  logic        read;
  logic [7:0]  readdata;
  logic [15:0] ingress_port_tdata;
  logic        ingress_port_tvalid;
  logic        ingress_port_tlast;
  logic        ingress_port_tready;
  modport master (
    output writedata, write, chipselect, address, read,
    output ingress_port_tdata, ingress_port_tvalid, ingress_port_tlast,
    input  readdata, ingress_port_tready
  );
  modport slave (
    input  writedata, write, chipselect, address, read,
    input  ingress_port_tdata, ingress_port_tvalid, ingress_port_tlast,
    output readdata, ingress_port_tready
  );
endinterface

// File: rtl/frame_checker.sv
// frame_checker: parses 16-bit stream frames, checks length vs tlast, sums payload, exposes results over Avalon-MM
// Ports: clk, reset (sync, active-high); bus (frame_checker_if.slave): Avalon writedata/write/chipselect/
// address/read -> readdata (1-cycle, registered), stream tdata/tvalid/tlast -> tready.
// Optional: FRAME_CHECKER_STALL_EN adds an R/W stall mask at address 24 that gates tready per clock phase.
module frame_checker #(
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            reset,
  frame_checker_if.slave bus
);
  typedef enum logic [1:0] {HDR, PAY, DISCARD} state_t;
  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      cks_q, cks_d, vcks_q;
  logic [7:0]       sh_q [16];
  logic [7:0]       vis_q [16];
  logic [CNT_W-1:0] good_q, err_q;
  logic             last_err_q, runt_st_q, len_st_q;
  logic             good_ev_q, runt_ev_q, len_ev_q, clr_q;
  logic             good_d, runt_d, len_d;
  logic [7:0]       rdata_q, rmux, status, mask_rd;
  logic [15:0]      len, last_idx;
  logic             beat, last, odd_end, rdy;
  // length lives in shadow bytes 12 (LSB) and 13; the final payload beat index is 7 + ceil(len/2)
  assign len      = {sh_q[13], sh_q[12]};
  assign last_idx = 16'(17'd7 + ((17'(len) + 17'd1) >> 1));
  assign beat     = bus.ingress_port_tvalid && rdy;
  assign last     = bus.ingress_port_tlast;
  assign odd_end  = cnt_q == last_idx && len[0];
`ifdef FRAME_CHECKER_STALL_EN
  logic [7:0] mask_q;
  logic [2:0] phase_q;
  assign rdy     = !reset && mask_q[phase_q];
  assign mask_rd = mask_q;
  always_ff @(posedge clk)
    if (reset) begin
      mask_q  <= 8'hff;
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + 3'd1;
      if (bus.chipselect && bus.write && bus.address == 8'd24) mask_q <= bus.writedata;
    end
`else
  assign rdy     = !reset;
  assign mask_rd = 8'd0;
`endif
  assign bus.ingress_port_tready = rdy;
  assign bus.readdata            = rdata_q;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= HDR;
      cnt_q   <= '0;
      cks_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cks_q   <= cks_d;
    end
  always_comb begin
    state_d = state_q;
    if (beat)
      case (state_q)
        HDR:     state_d = (cnt_q == 16'd7 && !last) ? (len == 16'd0 ? DISCARD : PAY) : HDR;
        PAY:     state_d = last ? HDR : (cnt_q == last_idx ? DISCARD : PAY);
        default: state_d = last ? HDR : DISCARD;
      endcase
    cnt_d = beat ? (last ? 16'd0 : cnt_q + 16'd1) : cnt_q;
    // shadow sum restarts on beat 0; an odd length leaves a pad byte in the low lane of the final beat
    cks_d = (beat && state_q == HDR && cnt_q == 16'd0) ? 32'd0 :
            (beat && state_q == PAY) ? cks_q + 32'(bus.ingress_port_tdata[15:8]) +
                                       (odd_end ? 32'd0 : 32'(bus.ingress_port_tdata[7:0])) : cks_q;
  end
  always_comb begin
    good_d = beat && last && (state_q == HDR ? (cnt_q == 16'd7 && len == 16'd0)
                                             : (state_q == PAY && cnt_q == last_idx));
    runt_d = beat && last && state_q == HDR && cnt_q < 16'd7;
    len_d  = beat && last && !good_d && !runt_d;
  end
  // frame outcomes are registered, so commit and counters act the cycle after the final beat
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        sh_q[i]  <= '0;
        vis_q[i] <= '0;
      end
      vcks_q     <= '0;
      good_q     <= '0;
      err_q      <= '0;
      last_err_q <= 1'b0;
      runt_st_q  <= 1'b0;
      len_st_q   <= 1'b0;
      good_ev_q  <= 1'b0;
      runt_ev_q  <= 1'b0;
      len_ev_q   <= 1'b0;
      clr_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (beat && state_q == HDR) begin
        sh_q[{cnt_q[2:0], 1'b0}] <= bus.ingress_port_tdata[15:8];
        sh_q[{cnt_q[2:0], 1'b1}] <= bus.ingress_port_tdata[7:0];
      end
      good_ev_q <= good_d;
      runt_ev_q <= runt_d;
      len_ev_q  <= len_d;
      clr_q     <= bus.chipselect && bus.write && bus.address == 8'd23 && bus.writedata[0];
      if (good_ev_q) begin
        vis_q  <= sh_q;
        vcks_q <= cks_q;
      end
      if (clr_q) begin
        good_q    <= '0;
        err_q     <= '0;
        runt_st_q <= 1'b0;
        len_st_q  <= 1'b0;
      end else begin
        if (good_ev_q && good_q != '1) good_q <= good_q + CNT_W'(1);
        if ((runt_ev_q || len_ev_q) && err_q != '1) err_q <= err_q + CNT_W'(1);
        if (runt_ev_q) runt_st_q <= 1'b1;
        if (len_ev_q) len_st_q <= 1'b1;
      end
      if (good_ev_q) last_err_q <= 1'b0;
      else if (runt_ev_q || len_ev_q) last_err_q <= 1'b1;
      rdata_q <= (bus.chipselect && bus.read) ? rmux : 8'd0;
    end
  assign status = {4'd0, len_st_q, runt_st_q, last_err_q, state_q != HDR || cnt_q != 16'd0};
  always_comb
    rmux = bus.address < 8'd16  ? vis_q[bus.address[3:0]] :
           bus.address < 8'd20  ? vcks_q[{bus.address[1:0], 3'b000} +: 8] :
           bus.address == 8'd20 ? 8'(good_q) :
           bus.address == 8'd21 ? 8'(err_q) :
           bus.address == 8'd22 ? status :
           bus.address == 8'd24 ? mask_rd : 8'd0;
endmodule

// File: tb/tb_frame_checker.sv
// tb_frame_checker: directed self-checking bench for frame_checker
module tb_frame_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  frame_checker_if bus();
  frame_checker dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int passed = 0;
  logic [7:0] fb [256];
  logic [7:0] exp_hdr [16];

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd_cks(output logic [31:0] c);
    logic [7:0] v;
    for (int k = 0; k < 4; k++) begin
      rd(8'(16 + k), v);
      c[8*k +: 8] = v;
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l, input logic clr);
    int n = 0;
    bus.ingress_port_tdata = d; bus.ingress_port_tlast = l; bus.ingress_port_tvalid = 1'b1;
    while (!bus.ingress_port_tready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n == 64) begin
      total++;
      $display("FAIL tready_timeout: tready=%b after %0d cycles, required 1", bus.ingress_port_tready, n);
    end
    if (clr) begin
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 8'd23; bus.writedata = 8'h01;
    end
    @(negedge clk);
    bus.ingress_port_tvalid = 1'b0; bus.ingress_port_tlast = 1'b0;
    if (clr) begin
      bus.chipselect = 1'b0; bus.write = 1'b0;
    end
  endtask

  task automatic send_frame(input int nbeats, input bit gaps, input bit clr_last);
    for (int i = 0; i < nbeats; i++) begin
      send_beat({fb[2*i], fb[2*i+1]}, i == nbeats - 1, clr_last && i == nbeats - 1);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic set_hdr(input logic [15:0] len, input logic [15:0] typ);
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]   = 8'(i + 1);
      fb[6+i] = 8'(8'h11 + i);
    end
    fb[12] = len[7:0]; fb[13] = len[15:8]; fb[14] = typ[15:8]; fb[15] = typ[7:0];
  endtask

  task automatic note_hdr;
    for (int i = 0; i < 16; i++) exp_hdr[i] = fb[i];
  endtask

  task automatic test_reset;
    logic [7:0] v;
    reset = 1'b1;
    idle(3);
    total++;
    if (bus.readdata !== 8'h00 || bus.ingress_port_tready !== 1'b0)
      $display("FAIL reset_outputs: readdata=%h tready=%b, required 00/0", bus.readdata, bus.ingress_port_tready);
    else passed++;
    reset = 1'b0;
    idle(1);
    total++;
    if (bus.ingress_port_tready !== 1'b1) $display("FAIL reset_tready: got %b, required 1", bus.ingress_port_tready);
    else passed++;
    rd(8'd22, v);
    total++;
    if (v !== 8'h00) $display("FAIL reset_status: got %h, required 00", v); else passed++;
    rd(8'd20, v);
    total++;
    if (v !== 8'h00) $display("FAIL reset_good_cnt: got %h, required 00", v); else passed++;
    idle(1);
    total++;
    if (bus.readdata !== 8'h00) $display("FAIL idle_readdata: got %h, required 00", bus.readdata); else passed++;
  endtask

  task automatic test_good_len4;
    logic [7:0] v;
    logic [31:0] c;
    wr(8'd23, 8'h01);
    set_hdr(16'd4, 16'h0800);
    fb[16] = 8'h10; fb[17] = 8'h20; fb[18] = 8'h30; fb[19] = 8'h40;
    send_frame(10, 1'b0, 1'b0);
    idle(2);
    note_hdr();
    for (int a = 0; a < 16; a++) begin
      rd(8'(a), v);
      total++;
      if (v !== exp_hdr[a]) $display("FAIL good4_hdr[%0d]: got %h, required %h", a, v, exp_hdr[a]); else passed++;
    end
    rd_cks(c);
    total++;
    if (c !== 32'h000000a0) $display("FAIL good4_cks: got %h, required 000000a0", c); else passed++;
    rd(8'd20, v);
    total++;
    if (v !== 8'd1) $display("FAIL good4_good_cnt: got %h, required 01", v); else passed++;
    rd(8'd22, v);
    total++;
    if (v !== 8'h00) $display("FAIL good4_status: got %h, required 00", v); else passed++;
  endtask

  task automatic test_odd_len;
    logic [7:0] v;
    logic [31:0] c;
    wr(8'd23, 8'h01);
    set_hdr(16'd3, 16'h0800);
    fb[16] = 8'haa; fb[17] = 8'hbb; fb[18] = 8'hcc; fb[19] = 8'h55;
    send_frame(10, 1'b0, 1'b0);
    idle(2);
    note_hdr();
    rd_cks(c);
    total++;
    if (c !== 32'h00000231) $display("FAIL odd_cks: got %h, required 00000231", c); else passed++;
    rd(8'd20, v);
    total++;
    if (v !== 8'd1) $display("FAIL odd_good_cnt: got %h, required 01", v); else passed++;
    rd(8'd12, v);
    total++;
    if (v !== 8'h03) $display("FAIL odd_len_lsb: got %h, required 03", v); else passed++;
  endtask

  task automatic test_runt;
    logic [7:0] v;
    logic [31:0] c;
    wr(8'd23, 8'h01);
    set_hdr(16'd4, 16'h0800);
    fb[0] = 8'hee;
    send_frame(5, 1'b0, 1'b0);
    idle(2);
    rd(8'd21, v);
    total++;
    if (v !== 8'd1) $display("FAIL runt_err_cnt: got %h, required 01", v); else passed++;
    rd(8'd22, v);
    total++;
    if (v !== 8'h06) $display("FAIL runt_status: got %h, required 06", v); else passed++;
    rd(8'd0, v);
    total++;
    if (v !== exp_hdr[0]) $display("FAIL runt_dst0_kept: got %h, required %h", v, exp_hdr[0]); else passed++;
    rd(8'd12, v);
    total++;
    if (v !== exp_hdr[12]) $display("FAIL runt_len_kept: got %h, required %h", v, exp_hdr[12]); else passed++;
    rd_cks(c);
    total++;
    if (c !== 32'h00000231) $display("FAIL runt_cks_kept: got %h, required 00000231", c); else passed++;
  endtask

  task automatic test_overlong;
    logic [7:0] v;
    logic [31:0] c;
    wr(8'd23, 8'h01);
    set_hdr(16'd4, 16'h0800);
    send_frame(12, 1'b0, 1'b0);
    idle(2);
    rd(8'd21, v);
    total++;
    if (v !== 8'd1) $display("FAIL long_err_cnt: got %h, required 01", v); else passed++;
    rd(8'd22, v);
    total++;
    if (v !== 8'h0a) $display("FAIL long_status: got %h, required 0a", v); else passed++;
    set_hdr(16'd2, 16'h86dd);
    fb[16] = 8'h01; fb[17] = 8'h02;
    send_frame(9, 1'b0, 1'b0);
    idle(2);
    note_hdr();
    rd(8'd20, v);
    total++;
    if (v !== 8'd1) $display("FAIL after_long_good_cnt: got %h, required 01", v); else passed++;
    rd(8'd22, v);
    total++;
    if (v !== 8'h08) $display("FAIL after_long_status: got %h, required 08", v); else passed++;
    rd(8'd14, v);
    total++;
    if (v !== 8'h86) $display("FAIL after_long_type0: got %h, required 86", v); else passed++;
    rd_cks(c);
    total++;
    if (c !== 32'h00000003) $display("FAIL after_long_cks: got %h, required 00000003", c); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    logic [31:0] c;
    wr(8'd23, 8'h01);
    set_hdr(16'd4, 16'h0800);
    fb[16] = 8'h01; fb[17] = 8'h02; fb[18] = 8'h03; fb[19] = 8'h04;
    send_frame(10, 1'b0, 1'b0);
    set_hdr(16'd1, 16'h0800);
    fb[16] = 8'h7f; fb[17] = 8'h33;
    send_frame(9, 1'b0, 1'b0);
    idle(2);
    note_hdr();
    rd(8'd20, v);
    total++;
    if (v !== 8'd2) $display("FAIL b2b_good_cnt: got %h, required 02", v); else passed++;
    rd_cks(c);
    total++;
    if (c !== 32'h0000007f) $display("FAIL b2b_cks: got %h, required 0000007f", c); else passed++;
    rd(8'd12, v);
    total++;
    if (v !== 8'h01) $display("FAIL b2b_len_lsb: got %h, required 01", v); else passed++;
  endtask

  task automatic test_backpressure;
    logic [7:0] v;
    logic [31:0] c;
    wr(8'd23, 8'h01);
`ifdef FRAME_CHECKER_STALL_EN
    wr(8'd24, 8'h55);
    rd(8'd24, v);
    total++;
    if (v !== 8'h55) $display("FAIL stall_mask_rb: got %h, required 55", v); else passed++;
`else
    rd(8'd24, v);
    total++;
    if (v !== 8'h00) $display("FAIL addr24_zero: got %h, required 00", v); else passed++;
`endif
    set_hdr(16'd4, 16'h0800);
    fb[16] = 8'h10; fb[17] = 8'h20; fb[18] = 8'h30; fb[19] = 8'h40;
    send_frame(10, 1'b1, 1'b0);
    idle(4);
    note_hdr();
    rd_cks(c);
    total++;
    if (c !== 32'h000000a0) $display("FAIL bp_cks: got %h, required 000000a0", c); else passed++;
    rd(8'd20, v);
    total++;
    if (v !== 8'd1) $display("FAIL bp_good_cnt: got %h, required 01", v); else passed++;
    rd(8'd21, v);
    total++;
    if (v !== 8'd0) $display("FAIL bp_err_cnt: got %h, required 00", v); else passed++;
`ifdef FRAME_CHECKER_STALL_EN
    wr(8'd24, 8'hff);
`endif
  endtask

  task automatic test_saturation;
    logic [7:0] v;
    logic [31:0] c;
    wr(8'd23, 8'h01);
    set_hdr(16'd4, 16'h0800);
    send_frame(3, 1'b0, 1'b0);
    set_hdr(16'd0, 16'h0806);
    for (int f = 0; f < 300; f++) send_frame(8, 1'b0, 1'b0);
    idle(2);
    rd(8'd20, v);
    total++;
    if (v !== 8'hff) $display("FAIL sat_good_cnt: got %h, required ff", v); else passed++;
    rd(8'd21, v);
    total++;
    if (v !== 8'h01) $display("FAIL sat_err_cnt: got %h, required 01", v); else passed++;
    set_hdr(16'd2, 16'h0800);
    fb[0] = 8'h5a; fb[16] = 8'h05; fb[17] = 8'h06;
    send_frame(9, 1'b0, 1'b1);
    idle(2);
    rd(8'd20, v);
    total++;
    if (v !== 8'h00) $display("FAIL clr_good_cnt: got %h, required 00", v); else passed++;
    rd(8'd21, v);
    total++;
    if (v !== 8'h00) $display("FAIL clr_err_cnt: got %h, required 00", v); else passed++;
    rd(8'd22, v);
    total++;
    if (v !== 8'h00) $display("FAIL clr_status: got %h, required 00", v); else passed++;
    rd(8'd0, v);
    total++;
    if (v !== 8'h5a) $display("FAIL clr_hdr_commit: got %h, required 5a", v); else passed++;
    rd_cks(c);
    total++;
    if (c !== 32'h0000000b) $display("FAIL clr_cks_commit: got %h, required 0000000b", c); else passed++;
  endtask

  initial begin
    bus.writedata = '0; bus.write = 1'b0; bus.chipselect = 1'b0; bus.address = '0; bus.read = 1'b0;
    bus.ingress_port_tdata = '0; bus.ingress_port_tvalid = 1'b0; bus.ingress_port_tlast = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_len4();
    test_odd_len();
    test_runt();
    test_overlong();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
